// File: rtl/mul_sequencer.sv
// Sequencer for the EX-stage multi-cycle multiplier: launches it, stalls the pipeline, returns the product.
// Optional `MUL_ZERO_BYPASS_EN: a zero operand skips the multiplier and returns 0 after a one-cycle stall.
module mul_sequencer #(
  parameter int OP_W      = 16,
  parameter int ST_CYCLES = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  input  logic              mul_idle,
  input  logic              mul_done,
  input  logic [2*OP_W-1:0] mul_prod,
  output logic              mul_st,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  output logic              stall,
  output logic [2*OP_W-1:0] result,
  output logic              result_valid,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  localparam logic [3:0] ST_LAST = 4'(ST_CYCLES - 1);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t              state_q;
  logic [3:0]          st_cnt_q;
  logic [9:0]          wait_cnt_q;
  logic                done_q;
  logic                mul_st_q;
  logic [OP_W-1:0]     mul_a_q;
  logic [OP_W-1:0]     mul_b_q;
  logic [2*OP_W-1:0]   result_q;
  logic                result_valid_q;
  logic                timeout_err_q;
  logic                done_rise;
  logic                zero_bypass;

  // done is a level that may linger between ops, so only its rising edge completes a WAIT
  assign done_rise = mul_done & ~done_q;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_bypass = (op_a == '0) | (op_b == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  assign stall = ((state_q == S_IDLE) & req) | (state_q == S_LAUNCH) | (state_q == S_WAIT);

  assign mul_st       = mul_st_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      st_cnt_q       <= '0;
      wait_cnt_q     <= '0;
      done_q         <= 1'b1;
      mul_st_q       <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      done_q         <= mul_done;
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (zero_bypass) begin
              result_q       <= '0;
              result_valid_q <= 1'b1;
              state_q        <= S_DONE;
            end else if (mul_idle) begin
              mul_a_q  <= op_a;
              mul_b_q  <= op_b;
              mul_st_q <= 1'b1;
              st_cnt_q <= '0;
              state_q  <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (st_cnt_q == ST_LAST) begin
            mul_st_q   <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= S_WAIT;
          end else begin
            st_cnt_q <= st_cnt_q + 4'd1;
          end
        end
        S_WAIT: begin
          // a done edge arriving on the timeout cycle still counts as success
          if (done_rise) begin
            result_q       <= mul_prod;
            result_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end else if (wait_cnt_q == TO_LAST) begin
            result_q       <= '0;
            result_valid_q <= 1'b1;
            timeout_err_q  <= 1'b1;
            state_q        <= S_ABORT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 10'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ABORT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer (default parameters); the bench plays the multiplier.
module tb_mul_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req;
  logic [15:0] op_a, op_b;
  logic        mul_idle, mul_done;
  logic [31:0] mul_prod;
  logic        mul_st;
  logic [15:0] mul_a, mul_b;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        timeout_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  mul_sequencer #(.OP_W(16), .ST_CYCLES(2), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .req(req), .op_a(op_a), .op_b(op_b),
    .mul_idle(mul_idle), .mul_done(mul_done), .mul_prod(mul_prod),
    .mul_st(mul_st), .mul_a(mul_a), .mul_b(mul_b), .stall(stall),
    .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Accept, count mul_st cycles, raise done in WAIT cycle wait_n, then check the result pulse.
  // Returns at the negedge of the IDLE cycle following DONE.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] prod, input int wait_n, input int idle_wait);
    int st_cnt;
    req = 1'b1; op_a = a; op_b = b; mul_idle = (idle_wait == 0);
    #1 check({tag, " stall_req"}, stall, 1);
    for (int i = 0; i < idle_wait; i++) begin
      @(negedge CLK);
      check({tag, " busy_mul_st"}, mul_st, 0);
      check({tag, " busy_stall"}, stall, 1);
    end
    mul_idle = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    check({tag, " mul_a"}, mul_a, a);
    check({tag, " mul_b"}, mul_b, b);
    st_cnt = 0;
    while (mul_st === 1'b1 && st_cnt < 20) begin
      check({tag, " stall_launch"}, stall, 1);
      @(negedge CLK);
      st_cnt++;
    end
    check({tag, " mul_st_cycles"}, st_cnt, 2);
    for (int i = 1; i < wait_n; i++) begin
      check({tag, " stall_wait"}, stall, 1);
      @(negedge CLK);
    end
    check({tag, " no_early_valid"}, result_valid, 0);
    mul_done = 1'b1; mul_prod = prod;
    @(negedge CLK);
    mul_done = 1'b0;
    check({tag, " valid"}, result_valid, 1);
    check({tag, " result"}, result, prod);
    check({tag, " stall_done"}, stall, 0);
    @(negedge CLK);
    check({tag, " valid_pulse"}, result_valid, 0);
    check({tag, " result_hold"}, result, prod);
  endtask

  initial begin
    int st_cnt;
    RST = 1'b0; req = 1'b0; op_a = '0; op_b = '0;
    mul_idle = 1'b1; mul_done = 1'b1; mul_prod = 32'hDEADBEEF;
    repeat (3) @(negedge CLK);
    check("rst mul_st", mul_st, 0);
    check("rst result", result, 0);
    check("rst valid", result_valid, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst mul_a", mul_a, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst valid", result_valid, 0);
    check("post_rst stall", stall, 0);
    check("post_rst result", result, 0);
    mul_done = 1'b0;
    @(negedge CLK);

    do_mul("m300x7", 16'd300, 16'd7, 32'd2100, 5, 0);
    do_mul("busy5x5", 16'd5, 16'd5, 32'd25, 2, 3);

    // timeout: done never rises
    req = 1'b1; op_a = 16'd11; op_b = 16'd13; mul_idle = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    st_cnt = 0;
    while (mul_st === 1'b1 && st_cnt < 20) begin
      @(negedge CLK);
      st_cnt++;
    end
    check("to mul_st_cycles", st_cnt, 2);
    for (int i = 1; i < 64; i++) begin
      if (result_valid !== 1'b0 || stall !== 1'b1) check("to early_exit", {result_valid, stall}, 2'b01);
      @(negedge CLK);
    end
    check("to err_before", timeout_err, 0);
    check("to stall_wait64", stall, 1);
    @(negedge CLK);
    check("to valid", result_valid, 1);
    check("to result", result, 0);
    check("to err", timeout_err, 1);
    check("to stall", stall, 0);
    @(negedge CLK);
    check("to valid_pulse", result_valid, 0);

    do_mul("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 3, 0);
    do_mul("2x3", 16'd2, 16'd3, 32'd6, 1, 0);
    check("err sticky", timeout_err, 1);

`ifdef MUL_ZERO_BYPASS_EN
    req = 1'b1; op_a = 16'd0; op_b = 16'd9; mul_idle = 1'b0;
    #1 check("zb stall_req", stall, 1);
    @(negedge CLK);
    req = 1'b0;
    check("zb valid", result_valid, 1);
    check("zb result", result, 0);
    check("zb mul_st", mul_st, 0);
    check("zb stall", stall, 0);
    @(negedge CLK);
    check("zb valid_pulse", result_valid, 0);
    check("zb mul_st_after", mul_st, 0);
`else
    do_mul("zero", 16'd0, 16'd9, 32'd0, 2, 0);
`endif

    // reset mid-operation drops mul_st asynchronously and clears timeout_err
    req = 1'b1; op_a = 16'd4; op_b = 16'd4; mul_idle = 1'b1;
    @(negedge CLK);
    req = 1'b0;
    check("mid mul_st", mul_st, 1);
    RST = 1'b0;
    #1 check("mid async mul_st", mul_st, 0);
    check("mid err_clear", timeout_err, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid stall_idle", stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
